// File: rtl/exe_mul_hilo_unit_pkg.sv
// Shared types and constants for the EXE-stage multiplier / HI-LO unit.
package exe_mul_hilo_unit_pkg;

  localparam int unsigned MUL_ITERS = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

endpackage

// File: rtl/exe_mul_hilo_unit.sv
// Iterative radix-2 shift-add MULT/MULTU with the architectural HI/LO registers
// and the HI/LO / multiplier structural-hazard stall for the EXE stage.
module exe_mul_hilo_unit
  import exe_mul_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_ITERS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hilo_rd,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  mul_state_t        state;
  logic [CNT_W-1:0]  count;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  mplier;
  logic [PROD_W-1:0] acc;
  logic              neg;
  logic              done_q;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;

  logic [WIDTH-1:0]  mag_a_c;
  logic [WIDTH-1:0]  mag_b_c;
  logic [WIDTH-1:0]  addend_c;
  logic [WIDTH:0]    sum_c;
  logic [PROD_W-1:0] acc_next_c;
  logic [PROD_W-1:0] prod_c;
  logic              last_c;

  // Operand magnitudes; 2^(WIDTH-1) stays exact as an unsigned WIDTH-bit value.
  always_comb begin
    mag_a_c = op_a;
    mag_b_c = op_b;
    if (is_signed && op_a[WIDTH-1]) mag_a_c = ~op_a + WIDTH'(1);
    if (is_signed && op_b[WIDTH-1]) mag_b_c = ~op_b + WIDTH'(1);
  end

  // One shift-add step: carry-keeping add into the upper half, then shift right.
  always_comb begin
    addend_c   = mplier[0] ? mcand : '0;
    sum_c      = {1'b0, acc[PROD_W-1:WIDTH]} + {1'b0, addend_c};
    acc_next_c = {sum_c, acc[WIDTH-1:1]};
    prod_c     = neg ? (~acc_next_c + PROD_W'(1)) : acc_next_c;
    last_c     = (count == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            state  <= BUSY;
            mcand  <= mag_a_c;
            mplier <= mag_b_c;
            neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            count  <= '0;
            acc    <= '0;
          end
        end
        BUSY: begin
          if (flush) begin
            // Abort: HI/LO keep their architectural values, no done pulse.
            state <= IDLE;
          end else begin
            acc    <= acc_next_c;
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            count  <= count + CNT_W'(1);
            if (last_c) begin
              state  <= IDLE;
              hi_q   <= prod_c[PROD_W-1:WIDTH];
              lo_q   <= prod_c[WIDTH-1:0];
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == BUSY);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  // Only HI/LO readers and a following multiply wait on an in-flight operation.
  assign stall = busy & (hilo_rd | start);

endmodule

// File: tb/tb_exe_mul_hilo_unit.sv
// Scoreboard bench for exe_mul_hilo_unit: directed MULT/MULTU, stall, flush, reset.
module tb_exe_mul_hilo_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         hilo_rd;
  logic         flush;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2*W-1:0] exp_q[$];
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  exe_mul_hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .hilo_rd(hilo_rd), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every done pulse pops one expected {hi,lo}.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("sb_hi", 64'(hi), 64'(e[2*W-1:W]));
        check("sb_lo", 64'(lo), 64'(e[W-1:0]));
      end
    end
    if (done_prev) check("done_one_cycle", 64'(done), 64'(0));
    done_prev = done;
  end

  // Holds start until the unit is idle, then lets it be accepted on the next edge.
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] expv, input bit push);
    bit ok;
    ok        = 1'b0;
    start     = 1'b1;
    is_signed = sgn;
    op_a      = a;
    op_b      = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      check("stall_on_b2b_start", 64'(stall), 64'(1));
    end
    if (!ok) check("issue_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    if (push) exp_q.push_back(expv);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; returns at the negedge of the done cycle.
  task automatic wait_done(output int nbusy);
    bit ok;
    ok    = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) nbusy++;
      if (hilo_rd) check("stall_on_hilo_rd", 64'(stall), 64'(busy));
    end
    if (!ok) check("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int nb;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    hilo_rd = 1'b0; flush = 1'b0;
    tick(); tick();
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    rst = 1'b0;
    tick();

    // MULTU max x max, with 32 busy cycles
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    wait_done(nb);
    check("multu_busy_cycles", 64'(nb), 64'(32));
    tick(); tick();

    // MULT -1 x 1
    issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_done(nb);
    tick();

    // MULT most-negative squared
    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
    wait_done(nb);
    tick();

    // MULT 7x6, unrelated op passes, MFHI 3 cycles later stalls until done
    issue(1'b1, 32'd7, 32'd6, 64'd42, 1'b1);
    tick();
    check("unrelated_no_stall", 64'(stall), 64'(0));
    check("unrelated_busy", 64'(busy), 64'(1));
    tick(); tick();
    hilo_rd = 1'b1;
    wait_done(nb);
    check("mfhi_stall_released", 64'(stall), 64'(0));
    check("mfhi_hi", 64'(hi), 64'(0));
    check("mfhi_lo", 64'(lo), 64'(42));
    tick();
    hilo_rd = 1'b0;

    // Back-to-back MULTU: second start held until IDLE
    issue(1'b0, 32'd3, 32'd5, 64'd15, 1'b1);
    issue(1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);
    check("b2b_first_lo", 64'(lo), 64'(15));
    check("b2b_second_busy", 64'(busy), 64'(1));
    wait_done(nb);
    tick();

    // Flush at BUSY cycle 10: abort, no done, HI/LO retained
    issue(1'b0, 32'd9, 32'd9, 64'd0, 1'b0);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_done", 64'(done), 64'(0));
    check("flush_hi", 64'(hi), 64'(1));
    check("flush_lo", 64'(lo), 64'(0));
    repeat (40) tick();
    check("flush_stays_idle", 64'(busy), 64'(0));

    // start with flush in IDLE is not accepted
    start = 1'b1; flush = 1'b1; op_a = 32'd2; op_b = 32'd2;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_idle_no_accept", 64'(busy), 64'(0));
    tick();

    // Reset mid-BUSY
    issue(1'b0, 32'd3, 32'd3, 64'd0, 1'b0);
    repeat (5) tick();
    hilo_rd = 1'b1;
    rst = 1'b1;
    tick();
    check("midrst_hi", 64'(hi), 64'(0));
    check("midrst_lo", 64'(lo), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_stall", 64'(stall), 64'(0));
    rst = 1'b0;
    hilo_rd = 1'b0;
    repeat (3) tick();
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
